// File: rtl/cic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cic_pkg
//  Description : Shared CIC constants and data type. The integrator chain and
//                the decimation/comb section both use this package.
//  Revision    : 1.0  initial release
// ============================================================================
package cic_pkg;

   // Datapath width shared by the integrators and the combs
   localparam int CIC_WIDTH = 19;

   // One two's-complement CIC datapath word
   typedef logic signed [CIC_WIDTH-1:0] cic_data_t;

endpackage
`default_nettype wire

// File: rtl/cic_comb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : cic_comb_stage
//  Description : One registered CIC comb, y = x - x[n-M] in decimated samples.
//                The difference wraps modulo 2^WIDTH; CIC arithmetic relies on
//                that wrap, so there is no saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module cic_comb_stage
   import cic_pkg::*;
#(
   parameter int WIDTH = CIC_WIDTH,
   parameter int M     = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   // Differential delay line; element M-1 is the oldest decimated sample
   logic [WIDTH-1:0] r_dl [0:M-1];

   // On each decimated sample: take the difference, then shift the delay line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         for (int i = 0; i < M; i++) begin
            r_dl[i] <= '0;
         end
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= in_data - r_dl[M-1];
            r_dl[0]  <= in_data;
            for (int i = 1; i < M; i++) begin
               r_dl[i] <= r_dl[i-1];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/cic_decim_comb.sv
`default_nettype none
// ============================================================================
//  Module      : cic_decim_comb
//  Description : CIC decimator back end. Keeps one of every R integrator
//                outputs, runs it through N comb stages and presents the
//                truncated result over a valid/ready handshake. The combs never
//                stall; a sample that is not taken in time is overwritten and
//                the sticky overrun flag records it.
//  Revision    : 1.0  initial release
// ============================================================================
module cic_decim_comb
   import cic_pkg::*;
#(
   parameter int WIDTH     = CIC_WIDTH,
   parameter int R         = 8,
   parameter int N         = 3,
   parameter int M         = 1,
   parameter int OUT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 sync,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 overrun
);

   localparam int                 c_cnt_w    = (R > 1) ? $clog2(R) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(R - 1);

   logic [c_cnt_w-1:0] r_cnt;
   logic               r_v0;
   logic [WIDTH-1:0]   r_s0;
   logic               w_cnt_term;
   logic               w_capture;

   // Stage 0 is the decimated sample, stage N is the last comb output
   logic               w_v [0:N];
   logic [WIDTH-1:0]   w_y [0:N];

   assign w_cnt_term = (r_cnt == c_cnt_last);
   // sync takes priority over the terminal count, so no capture on a sync edge
   assign w_capture  = w_cnt_term && !sync;

   // Decimation phase counter: 0..R-1, restarted by sync
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (sync || w_cnt_term) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + c_cnt_w'(1);
      end
   end

   // Keep one integrator output per decimation period
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v0 <= 1'b0;
         r_s0 <= '0;
      end else begin
         r_v0 <= w_capture;
         if (w_capture) begin
            r_s0 <= in_data;
         end
      end
   end

   assign w_v[0] = r_v0;
   assign w_y[0] = r_s0;

   generate
      for (genvar k = 0; k < N; k++) begin : g_comb
         cic_comb_stage #(
            .WIDTH (WIDTH),
            .M     (M)
         ) u_comb (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (w_v[k]),
            .in_data   (w_y[k]),
            .out_valid (w_v[k+1]),
            .out_data  (w_y[k+1])
         );
      end
   endgenerate

   // Dropped LSBs are intentionally discarded (truncation, no rounding)
   generate
      if (OUT_WIDTH < WIDTH) begin : g_trunc
         logic w_unused_lsbs;
         assign w_unused_lsbs = ^w_y[N][WIDTH-OUT_WIDTH-1:0];
      end
   endgenerate

   // Output holding register: a new comb result always loads; an unread one is lost
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else if (w_v[N]) begin
         out_data  <= w_y[N][WIDTH-1 -: OUT_WIDTH];
         out_valid <= 1'b1;
         if (out_valid && !out_ready) begin
            overrun <= 1'b1;
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cic_decim_comb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cic_decim_comb
//  Description : Self-checking bench for cic_decim_comb. Three instances:
//                a (N=3, full width) step / backpressure / async reset,
//                b (N=1, full width) ramp across wrap and sync restarts,
//                c (N=1, 16-bit out) truncation table.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cic_decim_comb;
   import cic_pkg::*;

   localparam int R = 8;

   typedef struct {
      logic [18:0] data;
      int          due;
   } exp_t;

   typedef struct {
      int step;
      int exp;
   } trunc_vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;

   logic      rst_a   = 1'b0;
   logic      rst_bc  = 1'b0;
   logic      sync_a  = 1'b0;
   logic      sync_b  = 1'b0;
   logic      sync_c  = 1'b0;
   logic      ready_a = 1'b1;
   logic      ready_b = 1'b1;
   logic      ready_c = 1'b1;
   cic_data_t in_a    = '0;
   cic_data_t in_b    = '0;
   cic_data_t in_c    = '0;
   cic_data_t step_c  = '0;

   logic [18:0] od_a, od_b;
   logic [15:0] od_c;
   logic        ov_a, ov_b, ov_c, or_a, or_b, or_c;

   cic_decim_comb #(.WIDTH(19), .R(R), .N(3), .M(1), .OUT_WIDTH(19)) dut_a (
      .clk(clk), .rst_n(rst_a), .in_data(in_a), .sync(sync_a),
      .out_data(od_a), .out_valid(ov_a), .out_ready(ready_a), .overrun(or_a));

   cic_decim_comb #(.WIDTH(19), .R(R), .N(1), .M(1), .OUT_WIDTH(19)) dut_b (
      .clk(clk), .rst_n(rst_bc), .in_data(in_b), .sync(sync_b),
      .out_data(od_b), .out_valid(ov_b), .out_ready(ready_b), .overrun(or_b));

   cic_decim_comb #(.WIDTH(19), .R(R), .N(1), .M(1), .OUT_WIDTH(16)) dut_c (
      .clk(clk), .rst_n(rst_bc), .in_data(in_c), .sync(sync_c),
      .out_data(od_c), .out_valid(ov_c), .out_ready(ready_c), .overrun(or_c));

   // ---------------- reference model / scoreboard ----------------
   exp_t        qa[$];
   exp_t        qb[$];
   logic [18:0] ha[0:3];
   logic [18:0] hb[0:3];
   int          cnt_a = 0, cnt_b = 0;
   int          acc_a = 0, acc_b = 0;
   int          lost_a = 0, lost_b = 0;
   bit          lat_a = 1'b1;
   int          step_got[0:7];

   // N-th order difference with binomial weights, h[0] newest, wraps at 19 bits
   function automatic logic [18:0] cic_ref(input logic [18:0] h[0:3], input int n);
      logic [18:0] acc;
      int          c;
      acc = '0;
      c   = 1;
      for (int j = 0; j <= n; j++) begin
         if (j % 2 == 0) acc = acc + 19'(c) * h[j];
         else            acc = acc - 19'(c) * h[j];
         c = c * (n - j) / (j + 1);
      end
      return acc;
   endfunction

   always @(posedge clk) begin : model
      logic [18:0] nh[0:3];
      edge_n <= edge_n + 1;
      if (!rst_a) begin
         cnt_a <= 0;
         for (int i = 0; i < 4; i++) ha[i] <= '0;
      end else if (sync_a) begin
         cnt_a <= 0;
      end else if (cnt_a == R - 1) begin
         nh[0] = in_a;
         for (int i = 1; i < 4; i++) nh[i] = ha[i-1];
         ha <= nh;
         qa.push_back('{cic_ref(nh, 3), edge_n + 1 + 4});
         cnt_a <= 0;
      end else begin
         cnt_a <= cnt_a + 1;
      end
      if (!rst_bc) begin
         cnt_b <= 0;
         for (int i = 0; i < 4; i++) hb[i] <= '0;
      end else if (sync_b) begin
         cnt_b <= 0;
      end else if (cnt_b == R - 1) begin
         nh[0] = in_b;
         for (int i = 1; i < 4; i++) nh[i] = hb[i-1];
         hb <= nh;
         qb.push_back('{cic_ref(nh, 1), edge_n + 1 + 2});
         cnt_b <= 0;
      end else begin
         cnt_b <= cnt_b + 1;
      end
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      int   n;
      if (rst_a && ready_a && lat_a) begin
         while (qa.size() > 0 && qa[0].due < edge_n) begin
            e = qa.pop_front();
            lost_a++;
            $display("lost sample on a, due edge %0d", e.due);
         end
      end
      if (rst_a && ov_a && ready_a) begin
         n = 0;
         while (qa.size() > 0 && qa[0].due <= edge_n) begin
            e = qa.pop_front();
            n++;
         end
         checks++;
         if (n == 0) begin
            errors++;
            $display("FAIL a_spurious: out_valid=1 at edge %0d, required no sample pending", edge_n);
         end else begin
            if (od_a !== e.data) begin
               errors++;
               $display("FAIL a_data: out_data=%0d, required %0d", $signed(od_a), $signed(e.data));
            end
            if (lat_a) begin
               checks++;
               if (n != 1 || e.due != edge_n) begin
                  errors++;
                  $display("FAIL a_latency: output at edge %0d, required edge %0d", edge_n, e.due);
               end
            end
            if (n > 1) begin
               checks++;
               if (or_a !== 1'b1) begin
                  errors++;
                  $display("FAIL a_overrun_flag: overrun=%b, required 1", or_a);
               end
            end
            if (acc_a < 8) step_got[acc_a] = int'($signed(od_a));
            acc_a++;
         end
      end
      if (rst_bc && ready_b) begin
         while (qb.size() > 0 && qb[0].due < edge_n) begin
            e = qb.pop_front();
            lost_b++;
            $display("lost sample on b, due edge %0d", e.due);
         end
      end
      if (rst_bc && ov_b && ready_b) begin
         n = 0;
         while (qb.size() > 0 && qb[0].due <= edge_n) begin
            e = qb.pop_front();
            n++;
         end
         checks++;
         if (n != 1) begin
            errors++;
            $display("FAIL b_timing: %0d samples due at edge %0d, required 1", n, edge_n);
         end else if (od_b !== e.data || e.due != edge_n) begin
            errors++;
            $display("FAIL b_data: out_data=%0d at edge %0d, required %0d at edge %0d",
                     $signed(od_b), edge_n, $signed(e.data), e.due);
         end
         acc_b++;
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, exp);
      end
   endtask

   function automatic int n_due_a();
      int n = 0;
      foreach (qa[i]) if (qa[i].due <= edge_n) n++;
      return n;
   endfunction

   task automatic check_step(input string tag);
      int exp_step[0:4] = '{100, -200, 100, 0, 0};
      for (int k = 0; k < 5; k++)
         check($sformatf("%s_step%0d", tag, k), step_got[k], exp_step[k]);
   endtask

   task automatic wait_acc_a(input int target, input string tag);
      int t = 0;
      while (acc_a < target && t < 200) begin @(negedge clk); t++; end
      check(tag, longint'(acc_a >= target), 1);
   endtask

   task automatic wait_acc_b(input int target, input string tag);
      int t = 0;
      while (acc_b < target && t < 200) begin @(negedge clk); t++; end
      check(tag, longint'(acc_b >= target), 1);
   endtask

   task automatic wait_c_valid();
      int t = 0;
      do begin @(negedge clk); t++; end while (!ov_c && t < 40);
      check("c_valid_wait", longint'(ov_c), 1);
   endtask

   task automatic pulse_sync_b(input int at_cnt, input string tag);
      int t = 0;
      @(posedge clk); #1;
      while (cnt_b != at_cnt && t < 40) begin @(posedge clk); #1; t++; end
      check(tag, longint'(cnt_b == at_cnt), 1);
      sync_b = 1'b1;
      @(posedge clk); #1;
      sync_b = 1'b0;
   endtask

   // ---------------- sequences ----------------
   task automatic a_seq();
      int t;
      #2;
      check("a_rst_valid", ov_a, 0);
      check("a_rst_data", od_a, 0);
      check("a_rst_overrun", or_a, 0);
      in_a = 19'sd100;
      repeat (2) @(negedge clk);
      rst_a = 1'b1;
      wait_acc_a(5, "a_step_wait");
      check_step("a");

      // backpressure for two decimated periods
      @(posedge clk); #1;
      in_a = 19'sd300; ready_a = 1'b0; lat_a = 1'b0;
      t = 0;
      while (n_due_a() < 2 && t < 100) begin @(posedge clk); #1; t++; end
      check("a_bp_wait", longint'(n_due_a() >= 2), 1);
      repeat (2) @(posedge clk);
      #1;
      check("a_bp_valid", ov_a, 1);
      check("a_bp_overrun", or_a, 1);
      ready_a = 1'b1;
      @(posedge clk); #1;
      ready_a = 1'b0;
      check("a_bp_valid_fall", ov_a, 0);
      check("a_bp_overrun_sticky", or_a, 1);

      // asynchronous reset while a sample is held
      t = 0;
      while (ov_a !== 1'b1 && t < 40) begin @(posedge clk); #1; t++; end
      check("a_pre_reset_valid", ov_a, 1);
      #2;
      rst_a = 1'b0;
      #1;
      check("a_async_valid", ov_a, 0);
      check("a_async_data", od_a, 0);
      check("a_async_overrun", or_a, 0);
      qa.delete();
      acc_a = 0; in_a = 19'sd100; ready_a = 1'b1; lat_a = 1'b1;
      repeat (2) @(negedge clk);
      rst_a = 1'b1;
      wait_acc_a(5, "a_restep_wait");
      check_step("a_after_reset");
   endtask

   task automatic b_seq();
      #2;
      check("b_rst_data", od_b, 0);
      check("b_rst_valid", ov_b, 0);
      repeat (2) @(negedge clk);
      rst_bc = 1'b1;
      wait_acc_b(12, "b_wrap_wait");
      pulse_sync_b(5, "b_sync_mid");
      wait_acc_b(acc_b + 2, "b_sync_mid_wait");
      pulse_sync_b(R - 1, "b_sync_term");
      wait_acc_b(acc_b + 3, "b_sync_term_wait");
      check("b_no_overrun", or_b, 0);
   endtask

   task automatic c_seq();
      trunc_vec_t tv[0:6] = '{'{64, 64}, '{1, 1}, '{-64, -64}, '{1000, 1000},
                              '{-3, -3}, '{30000, 30000}, '{-32768, -32768}};
      #2;
      check("c_rst_valid", ov_c, 0);
      wait (rst_bc);
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         step_c = 19'(tv[i].step);
         repeat (4) wait_c_valid();
         check($sformatf("c_trunc_step%0d", tv[i].step), longint'($signed(od_c)), tv[i].exp);
      end
      check("c_no_overrun", or_c, 0);
   endtask

   // ramp drivers for b (+1 per clock, wraps through 0x7FFFF) and c (+step_c)
   initial begin
      in_b = 19'h7FFC0;
      forever begin
         @(posedge clk); #1;
         if (rst_bc) begin
            in_b = in_b + 19'd1;
            in_c = in_c + step_c;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, required completion before 100000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      fork
         a_seq();
         b_seq();
         c_seq();
      join
      check("lost_samples", lost_a + lost_b, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
